ps2_key_display: RTL and testbench
==================================

PS2_KEY_DISPLAY -- requirements
Module: ps2_key_display

Interface
REQ-001 The block SHALL have parameter SEG_ACTIVE_LOW, default 1, which selects the segment polarity (1 = a lit segment is driven to 0).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, the single clock of the block.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (asserted when 0).
REQ-004 The block SHALL have port scan_valid, input, 1 bit: a one-cycle pulse marking a new byte from the upstream PS/2 receiver.
REQ-005 The block SHALL have port scan_data, input, 8 bits: the received scancode byte, qualified by scan_valid.
REQ-006 The block SHALL have port key_down, output, 1 bit: 1 while a make code is held.
REQ-007 The block SHALL have port key_count, output, 8 bits: the number of distinct key presses since reset.
REQ-008 The block SHALL have ports seg0 and seg1, outputs, 8 bits each: the low and high hex digit of the held scancode.
REQ-009 The block SHALL have ports seg2 and seg3, outputs, 8 bits each: the low and high hex digit of the held key's ASCII code.
REQ-010 The block SHALL have ports seg4 and seg5, outputs, 8 bits each: the low and high hex digit of key_count.

Function
REQ-011 Segment bits SHALL map as bit0=a through bit6=g and bit7=dp, and dp SHALL always be unlit.
REQ-012 Active-high digit patterns SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-013 When SEG_ACTIVE_LOW=1 the segment outputs SHALL be the bitwise inverse of the active-high patterns.
REQ-014 Blank SHALL be all segments unlit: FF when active-low, 00 when active-high.
REQ-015 The FSM SHALL have three states: IDLE, HELD and BREAK.
REQ-016 Bytes SHALL be processed only on cycles with scan_valid=1; with scan_valid=0 all state SHALL hold.
REQ-017 A byte of E0 SHALL be discarded in every state, with no change to state, held code or count.
REQ-018 In IDLE, a byte of F0 SHALL move the FSM to BREAK.
REQ-019 In IDLE, any other byte SHALL be captured into held_code, SHALL increment key_count, and SHALL move the FSM to HELD.
REQ-020 In HELD, a byte equal to held_code (typematic repeat) SHALL leave state and count unchanged.
REQ-021 In HELD, a byte of F0 SHALL move the FSM to BREAK.
REQ-022 In HELD, any other byte SHALL be captured into held_code, SHALL increment key_count, and SHALL keep the FSM in HELD.
REQ-023 In BREAK, the next byte (other than E0) SHALL be consumed as the release code.
REQ-024 In BREAK, if the release code equals held_code while a key is held, the FSM SHALL go to IDLE.
REQ-025 In BREAK, otherwise the FSM SHALL return to the state it was in before F0 (HELD if a key was held, else IDLE), with held_code unchanged.
REQ-026 key_down SHALL be 1 when a key is held, including while in BREAK entered from HELD.
REQ-027 key_count SHALL be 8 bits, SHALL wrap from FF to 00, and SHALL increment by at most 1 per scan_valid.
REQ-028 The ASCII lookup SHALL be combinational from held_code and cover letters A-Z as uppercase and digits 0-9 (1C->41 'A', 32->42, 21->43, 23->44, 24->45, 2B->46, 34->47, 33->48, 43->49, 3B->4A, 42->4B, 4B->4C, 3A->4D, 31->4E, 44->4F, 4D->50, 15->51, 2D->52, 1B->53, 2C->54, 3C->55, 2A->56, 1D->57, 22->58, 35->59, 1A->5A, 45->30, 16->31, 1E->32, 26->33, 25->34, 2E->35, 36->36, 3D->37, 3E->38, 46->39).
REQ-029 Unmapped scancodes SHALL give ASCII 00, which displays as "00".
REQ-030 Segment outputs SHALL be combinational decodes of registered state only, with no path from scan_data to any output.
REQ-031 Outputs SHALL reflect each byte immediately after the clock edge that samples its scan_valid (latency of 1 edge).
REQ-032 seg0..seg3 SHALL be blank when key_down=0.
REQ-033 seg4 and seg5 SHALL always show key_count.

Reset
REQ-034 When rst=0 at a clock edge, the FSM SHALL go to IDLE, held_code SHALL be 00 and key_count SHALL be 00, regardless of any concurrent scan_valid.
REQ-035 During and after reset, key_down SHALL be 0, seg0..seg3 SHALL be blank, and seg4/seg5 SHALL show "00" (C0/C0 when active-low).
REQ-036 A reset asserted in BREAK SHALL discard the pending F0.

Verification
REQ-037 The bench SHALL cover reset then idle: key_down=0, key_count=00, seg0..3=FF, seg4=seg5=C0.
REQ-038 The bench SHALL cover the byte sequence 1C, F0, 1C: after 1C, key_down=1, seg1/seg0="1C", seg3/seg2="41", count=01; after 1C release, key_down=0, seg0..3=FF, count=01.
REQ-039 The bench SHALL cover the byte sequence 16, 16, 16, F0, 16: count=01 throughout the repeats, ASCII display shows "31", then the display blanks after release.
REQ-040 The bench SHALL cover the byte sequence 1C, 32, F0, 1C: count=02, held_code=32 remains displayed ("42"), key_down=1.
REQ-041 The bench SHALL cover the byte sequence E0, 75, E0, F0, E0, 75: count=01 after 75, E0 bytes are ignored, display blanks at the end, and the ASCII display shows "00" while 75 is held.
REQ-042 The bench SHALL cover 256 distinct presses: count wraps to 00, and rst=0 asserted mid-BREAK returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/ps2_key_display.sv
// ps2_key_display: tracks the currently held PS/2 key and shows it on six
// seven-segment digits.
//
// Parameters:
//   SEG_ACTIVE_LOW - 1: a lit segment is driven to 0; 0: a lit segment is driven to 1
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active low
//   scan_valid - one-cycle strobe qualifying scan_data
//   scan_data  - scancode byte from the PS/2 receiver
//   key_down   - 1 while a make code is held
//   key_count  - number of distinct key presses since reset (wraps)
//   seg0/seg1  - low/high hex digit of the held scancode (blank when no key held)
//   seg2/seg3  - low/high hex digit of the held key's ASCII code (blank when no key held)
//   seg4/seg5  - low/high hex digit of key_count
// Segment bits: bit0=a .. bit6=g, bit7=dp (dp always unlit).
module ps2_key_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_data,
    output logic       key_down,
    output logic [7:0] key_count,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5
);

    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeBreak = 8'hF0;

    typedef enum logic [1:0] {StIdle, StHeld, StBreak} state_e;

    state_e     state_q, state_d;
    logic       held_q, held_d;        // a key is held; survives BREAK so it can be resumed
    logic [7:0] held_code_q, held_code_d;
    logic [7:0] count_q, count_d;
    logic [7:0] ascii;

    // Active-high pattern for one hex digit (bits g..a).
    function automatic logic [6:0] hex_pat(input logic [3:0] d);
        logic [6:0] p;
        unique case (d)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            4'hF: p = 7'h71;
        endcase
        return p;
    endfunction

    // Apply blanking and output polarity; dp stays unlit.
    function automatic logic [7:0] seg_drive(input logic [3:0] d, input logic show);
        logic [7:0] raw;
        raw = show ? {1'b0, hex_pat(d)} : 8'h00;
        return SEG_ACTIVE_LOW ? ~raw : raw;
    endfunction

    // Set-2 scancode to uppercase ASCII; unmapped codes give 00.
    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        logic [7:0] a;
        case (c)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        held_code_d = held_code_q;
        count_d     = count_q;
        // E0 prefixes are dropped outright in every state.
        if (scan_valid && (scan_data != CodeExt)) begin
            case (state_q)
                StIdle: begin
                    if (scan_data == CodeBreak) begin
                        state_d = StBreak;
                    end else begin
                        held_code_d = scan_data;
                        count_d     = count_q + 8'd1;
                        held_d      = 1'b1;
                        state_d     = StHeld;
                    end
                end
                StHeld: begin
                    if (scan_data == CodeBreak) begin
                        state_d = StBreak;
                    end else if (scan_data != held_code_q) begin
                        // A repeat of the held code is typematic and ignored.
                        held_code_d = scan_data;
                        count_d     = count_q + 8'd1;
                    end
                end
                StBreak: begin
                    if (held_q && (scan_data == held_code_q)) begin
                        held_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        // Release of some other key: resume where we were.
                        state_d = held_q ? StHeld : StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    held_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
            count_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            held_code_q <= held_code_d;
            count_q     <= count_d;
        end
    end

    assign ascii     = to_ascii(held_code_q);
    assign key_down  = held_q;
    assign key_count = count_q;
    assign seg0      = seg_drive(held_code_q[3:0], held_q);
    assign seg1      = seg_drive(held_code_q[7:4], held_q);
    assign seg2      = seg_drive(ascii[3:0], held_q);
    assign seg3      = seg_drive(ascii[7:4], held_q);
    assign seg4      = seg_drive(count_q[3:0], 1'b1);
    assign seg5      = seg_drive(count_q[7:4], 1'b1);

endmodule

// File: tb/tb_ps2_key_display.sv
// Directed bench for ps2_key_display (active-low segments).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ps2_key_display;

    logic       clk;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       key_down;
    logic [7:0] key_count;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_key_display #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_valid(scan_valid),
        .scan_data (scan_data),
        .key_down  (key_down),
        .key_count (key_count),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .seg4      (seg4),
        .seg5      (seg5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; byte is sampled on the next rising edge.
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_data  = b;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    // Reset with a competing byte present, which must be ignored.
    task automatic do_reset();
        rst        = 1'b0;
        scan_valid = 1'b1;
        scan_data  = 8'h1C;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        scan_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (key_down !== 1'b0) begin
            n_fail++; $display("FAIL reset_key_down: got %b want 0", key_down);
        end
        n_checks++;
        if (key_count !== 8'h00) begin
            n_fail++; $display("FAIL reset_count: got %h want 00", key_count);
        end
        n_checks++;
        if ({seg3, seg2, seg1, seg0} !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL reset_seg0_3: got %h want FFFFFFFF", {seg3, seg2, seg1, seg0});
        end
        n_checks++;
        if ({seg5, seg4} !== 16'hC0C0) begin
            n_fail++; $display("FAIL reset_seg4_5: got %h want C0C0", {seg5, seg4});
        end
        // Idle with junk on the data bus but no strobe: nothing moves.
        scan_data = 8'h32;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({key_down, key_count} !== 9'h000) begin
            n_fail++; $display("FAIL idle_hold: got %h want 000", {key_down, key_count});
        end
    endtask

    task automatic test_make_break();
        do_reset();
        send(8'h1C);
        n_checks++;
        if ({key_down, key_count} !== 9'h101) begin
            n_fail++; $display("FAIL make_1c_state: got %h want 101", {key_down, key_count});
        end
        // "1C" -> 1=F9 C=C6 ; "41" -> 4=99 1=F9 ; count "01" -> 0=C0 1=F9
        n_checks++;
        if ({seg3, seg2, seg1, seg0} !== 32'h99F9_F9C6) begin
            n_fail++; $display("FAIL make_1c_segs: got %h want 99F9F9C6", {seg3, seg2, seg1, seg0});
        end
        n_checks++;
        if ({seg5, seg4} !== 16'hC0F9) begin
            n_fail++; $display("FAIL make_1c_count_segs: got %h want C0F9", {seg5, seg4});
        end
        send(8'hF0);
        n_checks++;
        if ({key_down, seg0} !== 9'h1C6) begin
            n_fail++; $display("FAIL break_pending_held: got %h want 1C6", {key_down, seg0});
        end
        send(8'h1C);
        n_checks++;
        if ({key_down, key_count} !== 9'h001) begin
            n_fail++; $display("FAIL release_1c_state: got %h want 001", {key_down, key_count});
        end
        n_checks++;
        if ({seg3, seg2, seg1, seg0} !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL release_1c_blank: got %h want FFFFFFFF", {seg3, seg2, seg1, seg0});
        end
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(8'h16);
            n_checks++;
            if ({key_down, key_count} !== 9'h101) begin
                n_fail++; $display("FAIL repeat_%0d_count: got %h want 101", i, {key_down, key_count});
            end
        end
        // "16" -> 1=F9 6=82 ; "31" -> 3=B0 1=F9
        n_checks++;
        if ({seg3, seg2, seg1, seg0} !== 32'hB0F9_F982) begin
            n_fail++; $display("FAIL repeat_segs: got %h want B0F9F982", {seg3, seg2, seg1, seg0});
        end
        send(8'hF0);
        send(8'h16);
        n_checks++;
        if ({key_down, key_count, seg3, seg2, seg1, seg0} !== 41'h001_FFFF_FFFF) begin
            n_fail++; $display("FAIL repeat_release: got %h want 001FFFFFFFF",
                               {key_down, key_count, seg3, seg2, seg1, seg0});
        end
    endtask

    task automatic test_rollover();
        do_reset();
        send(8'h1C);
        send(8'h32);
        send(8'hF0);
        send(8'h1C);
        n_checks++;
        if ({key_down, key_count} !== 9'h102) begin
            n_fail++; $display("FAIL rollover_state: got %h want 102", {key_down, key_count});
        end
        // "32" -> 3=B0 2=A4 ; "42" -> 4=99 2=A4 ; count "02" -> C0 A4
        n_checks++;
        if ({seg3, seg2, seg1, seg0} !== 32'h99A4_B0A4) begin
            n_fail++; $display("FAIL rollover_segs: got %h want 99A4B0A4", {seg3, seg2, seg1, seg0});
        end
        n_checks++;
        if ({seg5, seg4} !== 16'hC0A4) begin
            n_fail++; $display("FAIL rollover_count_segs: got %h want C0A4", {seg5, seg4});
        end
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0);
        n_checks++;
        if ({key_down, key_count} !== 9'h000) begin
            n_fail++; $display("FAIL ext_prefix_ignored: got %h want 000", {key_down, key_count});
        end
        send(8'h75);
        n_checks++;
        if ({key_down, key_count} !== 9'h101) begin
            n_fail++; $display("FAIL ext_make_state: got %h want 101", {key_down, key_count});
        end
        // "75" -> 7=F8 5=92 ; unmapped ASCII "00" -> C0 C0
        n_checks++;
        if ({seg3, seg2, seg1, seg0} !== 32'hC0C0_F892) begin
            n_fail++; $display("FAIL ext_make_segs: got %h want C0C0F892", {seg3, seg2, seg1, seg0});
        end
        send(8'hE0);
        send(8'hF0);
        send(8'hE0);
        n_checks++;
        if ({key_down, key_count, seg0} !== 17'h10192) begin
            n_fail++; $display("FAIL ext_break_pending: got %h want 10192", {key_down, key_count, seg0});
        end
        send(8'h75);
        n_checks++;
        if ({key_down, key_count, seg3, seg2, seg1, seg0} !== 41'h001_FFFF_FFFF) begin
            n_fail++; $display("FAIL ext_release: got %h want 001FFFFFFFF",
                               {key_down, key_count, seg3, seg2, seg1, seg0});
        end
    endtask

    task automatic test_wrap_and_reset_in_break();
        do_reset();
        // Alternating codes: every byte is a new press.
        for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
        n_checks++;
        if ({key_count, seg5, seg4} !== 24'hFF_8E8E) begin
            n_fail++; $display("FAIL count_ff: got %h want FF8E8E", {key_count, seg5, seg4});
        end
        send(8'h32);
        n_checks++;
        if ({key_down, key_count, seg5, seg4} !== 25'h100_C0C0) begin
            n_fail++; $display("FAIL count_wrap: got %h want 100C0C0", {key_down, key_count, seg5, seg4});
        end
        send(8'hF0);
        // Reset while in BREAK, with the release byte presented concurrently.
        rst        = 1'b0;
        scan_valid = 1'b1;
        scan_data  = 8'h32;
        @(negedge clk);
        rst        = 1'b1;
        scan_valid = 1'b0;
        n_checks++;
        if ({key_down, key_count, seg3, seg2, seg1, seg0, seg5, seg4}
                !== 57'h000_FFFF_FFFF_C0C0) begin
            n_fail++; $display("FAIL reset_in_break: got %h want 000FFFFFFFFC0C0",
                               {key_down, key_count, seg3, seg2, seg1, seg0, seg5, seg4});
        end
        // Pending F0 must be gone: 32 is a fresh make.
        send(8'h32);
        n_checks++;
        if ({key_down, key_count, seg1, seg0} !== 25'h101_B0A4) begin
            n_fail++; $display("FAIL after_reset_make: got %h want 101B0A4",
                               {key_down, key_count, seg1, seg0});
        end
    endtask

    initial begin
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_make_break();
        test_typematic();
        test_rollover();
        test_extended();
        test_wrap_and_reset_in_break();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
